// File: rtl/mac_tx_pkg.sv
// rtl/mac_tx_pkg.sv - XGMII symbols, MAC header, TX FSM states and CRC-32 byte step
package mac_tx_pkg;

    localparam int W_CRC = 32;

    localparam logic [7:0] SYM_START = 8'hFB;
    localparam logic [7:0] SYM_TERM  = 8'hFD;
    localparam logic [7:0] SYM_IDLE  = 8'h07;
    localparam logic [7:0] SYM_ERR   = 8'hFE;

    // Preamble/SFD as two 4-lane words, lane 0 in the low byte; shared with the RX MAC.
    localparam int N_MAC_HDR = 2;
    localparam logic [N_MAC_HDR-1:0][3:0]  MAC_HDR_CTRL = {4'b0000, 4'b0001};
    localparam logic [N_MAC_HDR-1:0][31:0] MAC_HDR_DATA = {32'hD5555555, 32'h555555FB};

    localparam logic [W_CRC-1:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [6:0] {
        ST_IDLE  = 7'b0000001,
        ST_HDR   = 7'b0000010,
        ST_DATA  = 7'b0000100,
        ST_PAD   = 7'b0001000,
        ST_FCS   = 7'b0010000,
        ST_ABORT = 7'b0100000,
        ST_IPG   = 7'b1000000
    } state_t;

    function automatic logic [W_CRC-1:0] crc32_byte(input logic [W_CRC-1:0] crc, input logic [7:0] data);
        logic [W_CRC-1:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_crc32.sv
// rtl/mac_crc32.sv - reflected Ethernet CRC-32 register with per-byte enables, lane 0 first
module mac_crc32
    import mac_tx_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int W_BYTE     = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_crc_clr,
    input  logic [N_CHANNELS-1:0]        i_crc_en,
    input  logic [N_CHANNELS*W_BYTE-1:0] i_data,
    output logic [W_CRC-1:0]             o_crc
);

    logic [W_CRC-1:0] crc_d;

    always_comb begin
        crc_d = o_crc;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (i_crc_en[i]) begin
                crc_d = crc32_byte(crc_d, i_data[i*W_BYTE +: W_BYTE]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_crc <= '1;
        end else if (i_crc_clr) begin
            o_crc <= '1;
        end else begin
            o_crc <= crc_d;
        end
    end

endmodule

// File: rtl/mac_tx.sv
// rtl/mac_tx.sv - transmit MAC: AXIS payload to framed XGMII words with pad, FCS, /T/ and IPG
module mac_tx
    import mac_tx_pkg::*;
#(
    parameter int N_CHANNELS  = 4,
    parameter int W_BYTE      = 8,
    parameter int N_MIN_TRANS = 15,
    parameter int N_IPG_TRANS = 3
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_clk_en,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [N_CHANNELS-1:0]        s_axis_tkeep,
    input  logic [N_CHANNELS*W_BYTE-1:0] s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic [N_CHANNELS-1:0]        o_xgmii_ctrl,
    output logic [N_CHANNELS*W_BYTE-1:0] o_xgmii_data,
    output logic                         o_underrun
);

    localparam int W_DATA = N_CHANNELS * W_BYTE;
    localparam int W_K    = $clog2(N_CHANNELS + 1);
    localparam int W_CNT  = $clog2(N_MIN_TRANS + 1);
    localparam int W_IPG  = $clog2(N_IPG_TRANS + 1);
    localparam int W_HDR  = (N_MAC_HDR > 1) ? $clog2(N_MAC_HDR) : 1;
    localparam logic [W_DATA-1:0] IDLE_WORD = {N_CHANNELS{SYM_IDLE}};

    state_t             state_q, state_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic [W_K-1:0]     k_q, k_d;
    logic [W_IPG-1:0]   ipg_q, ipg_d;
    logic [W_HDR-1:0]   hdr_q, hdr_d;
    logic               fcs_ph_q, fcs_ph_d;

    // Stage A holds the word produced by the FSM; stage B merges FCS into a short last word.
    logic [W_DATA-1:0]     a_data_q, a_data_d;
    logic [N_CHANNELS-1:0] a_ctrl_q, a_ctrl_d;
    logic                  a_merge_q, a_merge_d;
    logic [W_K-1:0]        a_k_q, a_k_d;
    logic                  a_unr_q, a_unr_d;
    logic [W_DATA-1:0]     b_data;

    logic                  crc_clr;
    logic [N_CHANNELS-1:0] crc_en;
    logic [W_CRC-1:0]      crc, fcs;
    logic [W_K-1:0]        keep_cnt;
    logic [W_DATA-1:0]     beat_data;

    assign fcs = ~crc;
    assign s_axis_tready = (state_q == ST_DATA) && i_clk_en;

    always_comb begin
        keep_cnt  = '0;
        beat_data = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            keep_cnt = keep_cnt + W_K'(s_axis_tkeep[i]);
            if (s_axis_tkeep[i]) beat_data[i*W_BYTE +: W_BYTE] = s_axis_tdata[i*W_BYTE +: W_BYTE];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        ipg_d     = ipg_q;
        hdr_d     = hdr_q;
        fcs_ph_d  = fcs_ph_q;
        a_data_d  = IDLE_WORD;
        a_ctrl_d  = '1;
        a_merge_d = 1'b0;
        a_k_d     = '0;
        a_unr_d   = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = '0;
        case (state_q)
            ST_IDLE: begin
                crc_clr  = 1'b1;
                cnt_d    = '0;
                hdr_d    = '0;
                fcs_ph_d = 1'b0;
                if (int'(ipg_q) < N_IPG_TRANS) ipg_d = ipg_q + 1'b1;
                // This idle word itself counts toward the gap.
                if (s_axis_tvalid && (int'(ipg_q) + 1 >= N_IPG_TRANS)) state_d = ST_HDR;
            end
            ST_HDR: begin
                a_data_d = MAC_HDR_DATA[hdr_q];
                a_ctrl_d = MAC_HDR_CTRL[hdr_q];
                hdr_d    = hdr_q + 1'b1;
                if (hdr_q == W_HDR'(N_MAC_HDR - 1)) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    a_data_d = {N_CHANNELS{SYM_ERR}};
                    a_unr_d  = 1'b1;
                    state_d  = ST_ABORT;
                end else if (s_axis_tuser) begin
                    a_data_d = {N_CHANNELS{SYM_ERR}};
                    state_d  = ST_ABORT;
                end else begin
                    a_data_d = beat_data;
                    a_ctrl_d = '0;
                    crc_en   = s_axis_tkeep;
                    if (int'(cnt_q) < N_MIN_TRANS) cnt_d = cnt_q + 1'b1;
                    if (s_axis_tlast) begin
                        k_d = keep_cnt;
                        if (int'(cnt_q) + 1 < N_MIN_TRANS) begin
                            crc_en  = '1;
                            state_d = ST_PAD;
                        end else begin
                            state_d   = ST_FCS;
                            a_merge_d = (int'(keep_cnt) < N_CHANNELS);
                            a_k_d     = keep_cnt;
                        end
                    end
                end
            end
            ST_PAD: begin
                a_data_d = '0;
                a_ctrl_d = '0;
                crc_en   = '1;
                cnt_d    = cnt_q + 1'b1;
                if (int'(cnt_q) + 1 >= N_MIN_TRANS) begin
                    k_d     = W_K'(N_CHANNELS);
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                if (int'(k_q) == N_CHANNELS) begin
                    if (!fcs_ph_q) begin
                        a_data_d = fcs[W_DATA-1:0];
                        a_ctrl_d = '0;
                        fcs_ph_d = 1'b1;
                    end else begin
                        a_data_d[W_BYTE-1:0] = SYM_TERM;
                        ipg_d   = '0;
                        state_d = ST_IPG;
                    end
                end else begin
                    // Upper FCS bytes spill into lanes 0..k-1, then /T/ in lane k.
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        if (i < int'(k_q)) begin
                            a_data_d[i*W_BYTE +: W_BYTE] = fcs[(i + N_CHANNELS - int'(k_q))*W_BYTE +: W_BYTE];
                            a_ctrl_d[i] = 1'b0;
                        end else if (i == int'(k_q)) begin
                            a_data_d[i*W_BYTE +: W_BYTE] = SYM_TERM;
                        end
                    end
                    ipg_d   = '0;
                    state_d = ST_IPG;
                end
            end
            ST_ABORT: begin
                a_data_d[W_BYTE-1:0] = SYM_TERM;
                ipg_d   = '0;
                state_d = ST_IPG;
            end
            ST_IPG: begin
                ipg_d = ipg_q + 1'b1;
                if (int'(ipg_q) + 1 >= N_IPG_TRANS - 1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        b_data = a_data_q;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (a_merge_q && (i >= int'(a_k_q))) begin
                b_data[i*W_BYTE +: W_BYTE] = fcs[(i - int'(a_k_q))*W_BYTE +: W_BYTE];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            k_q          <= '0;
            ipg_q        <= W_IPG'(N_IPG_TRANS);
            hdr_q        <= '0;
            fcs_ph_q     <= 1'b0;
            a_data_q     <= IDLE_WORD;
            a_ctrl_q     <= '1;
            a_merge_q    <= 1'b0;
            a_k_q        <= '0;
            a_unr_q      <= 1'b0;
            o_xgmii_data <= IDLE_WORD;
            o_xgmii_ctrl <= '1;
            o_underrun   <= 1'b0;
        end else if (i_clk_en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            ipg_q        <= ipg_d;
            hdr_q        <= hdr_d;
            fcs_ph_q     <= fcs_ph_d;
            a_data_q     <= a_data_d;
            a_ctrl_q     <= a_ctrl_d;
            a_merge_q    <= a_merge_d;
            a_k_q        <= a_k_d;
            a_unr_q      <= a_unr_d;
            o_xgmii_data <= b_data;
            o_xgmii_ctrl <= a_ctrl_q;
            o_underrun   <= a_unr_q;
        end
    end

    mac_crc32 #(
        .N_CHANNELS (N_CHANNELS),
        .W_BYTE     (W_BYTE)
    ) u_crc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_crc_clr (crc_clr & i_clk_en),
        .i_crc_en  (crc_en & {N_CHANNELS{i_clk_en}}),
        .i_data    (a_data_d),
        .o_crc     (crc)
    );

endmodule

// File: tb/tb_mac_tx.sv
// tb/tb_mac_tx.sv - randomized frame bench for mac_tx against a byte-stream framing model
module tb_mac_tx;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_clk_en;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [3:0]  s_axis_tkeep;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [3:0]  o_xgmii_ctrl;
    logic [31:0] o_xgmii_data;
    logic        o_underrun;

    mac_tx dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_clk_en      (i_clk_en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .o_xgmii_ctrl  (o_xgmii_ctrl),
        .o_xgmii_data  (o_xgmii_data),
        .o_underrun    (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int en_mode = 0;
    initial begin
        i_clk_en = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (en_mode)
                1:       i_clk_en = ~i_clk_en;
                2:       i_clk_en = ($urandom_range(0, 2) != 0);
                default: i_clk_en = 1'b1;
            endcase
        end
    end

    // Monitor: collect words from SYM_START through the /T/ word, gaps and pulses.
    logic        en_at_edge = 1'b0;
    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];
    int          gaps[$];
    int          in_frame = 0, seen_t = 0, gap = 0;
    int          frames_done = 0, frames_exp = 0;
    int          unr_cnt = 0, n_unr = 0, tready_cnt = 0, exp_tready = 0;

    always @(posedge i_clk) en_at_edge <= i_clk_en;

    always @(negedge i_clk) begin
        if (s_axis_tready && i_clk_en) tready_cnt++;
        if (i_reset_n && en_at_edge) begin
            if (o_underrun) unr_cnt++;
            if (!in_frame) begin
                if (o_xgmii_ctrl[0] && o_xgmii_data[7:0] == 8'hFB) begin
                    in_frame = 1;
                    got_q.push_back({o_xgmii_ctrl, o_xgmii_data});
                    if (seen_t) gaps.push_back(gap);
                end else if (o_xgmii_ctrl == 4'hF && o_xgmii_data == 32'h07070707) begin
                    gap++;
                end else begin
                    got_q.push_back({o_xgmii_ctrl, o_xgmii_data});
                end
            end else begin
                got_q.push_back({o_xgmii_ctrl, o_xgmii_data});
                for (int l = 0; l < 4; l++) begin
                    if (o_xgmii_ctrl[l] && o_xgmii_data[l*8 +: 8] == 8'hFD) begin
                        in_frame = 0;
                    end
                end
                if (!in_frame) begin
                    gap = 0;
                    seen_t = 1;
                    frames_done++;
                end
            end
        end
    end

    function automatic logic [31:0] eth_fcs(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
        end
        return ~c;
    endfunction

    // Model: expected wire characters as {ctrl, byte}, then grouped into 4-lane words.
    task automatic build_expected(input logic [7:0] pay[$], input int kind, input int err_beat);
        logic [8:0]  ch[$];
        logic [7:0]  body[$];
        logic [31:0] f;
        logic [35:0] w;
        ch.push_back({1'b1, 8'hFB});
        repeat (6) ch.push_back({1'b0, 8'h55});
        ch.push_back({1'b0, 8'hD5});
        if (kind != 0) begin
            for (int i = 0; i < err_beat * 4; i++) ch.push_back({1'b0, pay[i]});
            repeat (4) ch.push_back({1'b1, 8'hFE});
        end else begin
            body = pay;
            if ((pay.size() + 3) / 4 < 15) while (body.size() < 60) body.push_back(8'h00);
            f = eth_fcs(body);
            foreach (body[i]) ch.push_back({1'b0, body[i]});
            for (int j = 0; j < 4; j++) ch.push_back({1'b0, f[j*8 +: 8]});
        end
        ch.push_back({1'b1, 8'hFD});
        while (ch.size() % 4 != 0) ch.push_back({1'b1, 8'h07});
        for (int wi = 0; wi < ch.size() / 4; wi++) begin
            for (int l = 0; l < 4; l++) begin
                w[32 + l]     = ch[wi*4 + l][8];
                w[l*8 +: 8]   = ch[wi*4 + l][7:0];
            end
            exp_q.push_back(w);
        end
        frames_exp++;
    endtask

    // kind: 0 normal, 1 underrun at err_beat, 2 tuser abort at err_beat; rst_beat>=0 resets mid-frame.
    task automatic send_frame(input int len, input int kind, input int err_beat, input int seq,
                              input int rst_beat, input bit drop);
        logic [7:0] pay[$];
        int nb;
        bit ok;
        for (int i = 0; i < len; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
        nb = (len + 3) / 4;
        if (rst_beat < 0) build_expected(pay, kind, err_beat);
        if (kind == 1) n_unr++;
        for (int b = 0; b < nb; b++) begin
            if (kind == 1 && b == err_beat) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                exp_tready++;
                for (int c = 0; c < 500 && frames_done < frames_exp; c++) @(negedge i_clk);
                return;
            end
            for (int l = 0; l < 4; l++) begin
                s_axis_tkeep[l]       = (b*4 + l < len);
                s_axis_tdata[l*8 +: 8] = (b*4 + l < len) ? pay[b*4 + l] : 8'($urandom);
            end
            s_axis_tlast  = (b == nb - 1) || (kind == 2 && b == err_beat);
            s_axis_tuser  = (kind == 2 && b == err_beat);
            s_axis_tvalid = 1'b1;
            ok = 0;
            for (int c = 0; c < 1000 && !ok; c++) begin
                @(negedge i_clk);
                ok = s_axis_tready && i_clk_en;
            end
            if (!ok) begin
                check("handshake_timeout", 64'd0, 64'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge i_clk);
            #1;
            exp_tready++;
            if (b == rst_beat) begin
                #1;
                i_reset_n = 1'b0;
                #1;
                check("rst_async_ctrl", 64'(o_xgmii_ctrl), 64'hF);
                check("rst_async_data", 64'(o_xgmii_data), 64'h07070707);
                check("rst_async_tready", 64'(s_axis_tready), 64'd0);
                s_axis_tvalid = 1'b0;
                got_q.delete();
                in_frame = 0;
                seen_t = 0;
                gap = 0;
                repeat (2) @(negedge i_clk);
                i_reset_n = 1'b1;
                return;
            end
            if (s_axis_tlast) break;
        end
        s_axis_tuser = 1'b0;
        if (drop) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic wait_done(input bit exact_gap);
        int n;
        for (int c = 0; c < 4000 && frames_done < frames_exp; c++) @(negedge i_clk);
        check("frames_done", 64'(frames_done), 64'(frames_exp));
        check("word_count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        foreach (gaps[i]) begin
            if (exact_gap && i > 0) check("ipg_exact", 64'(gaps[i]), 64'd3);
            else                    check("ipg_min", 64'(gaps[i] >= 3), 64'd1);
        end
        got_q.delete();
        exp_q.delete();
        gaps.delete();
    endtask

    initial begin
        int len, kind, nb, err;
        i_reset_n     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tkeep  = 4'h0;
        s_axis_tdata  = 32'h0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_ctrl", 64'(o_xgmii_ctrl), 64'hF);
        check("reset_data", 64'(o_xgmii_data), 64'h07070707);
        check("reset_tready", 64'(s_axis_tready), 64'd0);
        check("reset_underrun", 64'(o_underrun), 64'd0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        send_frame(64, 0, -1, 1, -1, 1);
        send_frame(61, 0, -1, 0, -1, 1);
        send_frame(10, 0, -1, 0, -1, 1);
        wait_done(0);

        send_frame(40, 1, 5, 0, -1, 1);
        send_frame(20, 2, 3, 0, -1, 1);
        wait_done(0);

        send_frame(30, 0, -1, 0, -1, 0);
        send_frame(12, 0, -1, 0, -1, 0);
        send_frame(57, 0, -1, 0, -1, 0);
        send_frame(64, 0, -1, 0, -1, 1);
        wait_done(1);

        en_mode = 1;
        send_frame(64, 0, -1, 1, -1, 1);
        send_frame(7, 0, -1, 0, -1, 1);
        wait_done(0);

        en_mode = 2;
        for (int f = 0; f < 8; f++) begin
            len  = $urandom_range(1, 90);
            nb   = (len + 3) / 4;
            kind = $urandom_range(0, 3);
            if (kind > 2 || (kind == 1 && nb < 2)) kind = 0;
            err  = (kind == 1) ? $urandom_range(1, nb - 1) : $urandom_range(0, nb - 1);
            send_frame(len, kind, err, 0, -1, 1);
        end
        wait_done(0);

        en_mode = 0;
        repeat (2) @(negedge i_clk);
        send_frame(48, 0, -1, 0, 4, 1);
        send_frame(25, 0, -1, 0, -1, 1);
        wait_done(0);

        check("underrun_pulses", 64'(unr_cnt), 64'(n_unr));
        check("tready_cycles", 64'(tready_cnt), 64'(exp_tready));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
